proc_run_ctrl: RTL and testbench
================================

# proc_run_ctrl

Parametrised run/status controller for the Y86-64 core. It owns the architectural PC register and the one-hot status word (AOK/HLT/ADR/INS), and gates core advance through a run/step/stop state machine. It also holds a table of PC breakpoints and provides saturating cycle and retired-instruction counters. It sits between the fetch/PC-update stages and the testbench/debug host, and replaces free-running PC feedback and simulation-terminating status logic.

## Interface
- PC_W, 64, width of PC and breakpoint addresses
- RESET_PC, 0, PC value loaded on reset
- NUM_BP, 4, number of breakpoint entries (≥1); index width BI_W = max(1, clog2(NUM_BP))
- CNT_W, 32, width of cycle and instruction counters
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- run_req  in  1  start free-running execution (IDLE only)
- step_req  in  1  execute exactly one instruction (IDLE only)
- stop_req  in  1  return to IDLE after the current commit (RUN only)
- pc_next  in  PC_W  next PC from PC-update stage
- instr_valid  in  1  fetch decoded a legal instruction
- halt  in  1  current instruction is halt
- imem_error  in  1  fetch address fault
- dmem_error  in  1  data memory address fault
- bp_we  in  1  breakpoint table write strobe
- bp_idx  in  BI_W  entry to write
- bp_addr  in  PC_W  breakpoint address
- bp_valid  in  1  enable bit for written entry
- pc  out  PC_W  architectural PC
- stat  out  4  one-hot {AOK,HLT,ADR,INS}
- core_en  out  1  core may commit this cycle
- run_state  out  2  IDLE=0, RUN=1, STEP=2, STOP=3
- bp_hit  out  1  one-cycle pulse on breakpoint stop
- cycle_cnt  out  CNT_W  cycles spent in RUN/STEP
- instr_cnt  out  CNT_W  instructions committed

## Operation
- Reset: run_state=IDLE, pc=RESET_PC, stat=4'b1000, cycle_cnt=0, instr_cnt=0, bp_hit=0, all bp entries invalid with address 0.
- core_en is 1 exactly when run_state is RUN or STEP (combinational from state).
- IDLE: run_req→RUN; else step_req→STEP; run_req wins if both are asserted. stop_req is ignored.
- Commit cycle = posedge with core_en=1. Exception priority on the sampled inputs:
  - !instr_valid → INS (4'b0001)
  - else halt → HLT (4'b0100)
  - else imem_error|dmem_error → ADR (4'b0010)
- Exception on commit: stat latched, pc unchanged, instr_cnt unchanged, →STOP.
- Normal commit: pc<=pc_next, instr_cnt+1. Then evaluate in order:
  - pc_next matches any valid entry → IDLE, bp_hit=1 next cycle
  - else in RUN with stop_req → IDLE
  - else STEP → IDLE
  - else remain in RUN
- STOP: terminal until reset. core_en=0; all requests are ignored; stat holds.
- Counters: cycle_cnt +1 on every posedge where core_en=1, including the exception cycle. Both counters saturate at 2^CNT_W−1.
- Breakpoint writes are accepted in any state:
  - bp_idx ≥ NUM_BP is ignored.
  - A write and a hit compare in the same cycle use the pre-write table contents.
- Simultaneous events: an exception beats both a breakpoint and stop_req (→STOP, bp_hit stays 0). A breakpoint beats stop_req (→IDLE, bp_hit=1).

## Timing
- Request accepted at posedge N in IDLE → core_en=1 from N until the posedge after N.
- First commit happens at posedge N+1.
- STEP: exactly one commit, then IDLE with core_en=0 after that posedge.
- pc, stat, run_state, and counters update on the commit posedge and are visible immediately after it.
- bp_hit is high for the one cycle following the stopping commit.
- reset during RUN/STEP/STOP: all outputs take reset values at that posedge. No commit occurs on a reset cycle.

## Test plan
- Reset with RESET_PC=421 → pc=421, stat=4'b1000, run_state=0, core_en=0, counters 0.
- step_req in IDLE, pc_next=431, no errors → one commit: pc=431, instr_cnt=1, cycle_cnt=1, back to IDLE; a second step_req → pc tracks the new pc_next.
- run_req, pc_next increments by 10 per commit, entry 2 = {431, valid} → stops in IDLE with pc=431, bp_hit pulse of 1 cycle, instr_cnt=1.
- RUN; at the 3rd commit halt=1 and dmem_error=1 → stat=4'b0100, pc unchanged, run_state=3, instr_cnt=2, cycle_cnt=3; later run_req ignored.
- RUN with instr_valid=0, imem_error=1, and a matching breakpoint in one cycle → stat=4'b0001, STOP, bp_hit=0.
- CNT_W=3: run 10 commits → instr_cnt and cycle_cnt saturate at 7. reset asserted mid-RUN → all outputs return to reset values next posedge.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// Run/step/stop controller for the Y86-64 core: owns the architectural PC and status word,
// gates commits, and provides PC breakpoints plus saturating cycle/instruction counters.
module proc_run_ctrl #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              NUM_BP   = 4,
  parameter int              CNT_W    = 32,
  localparam int             BI_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             stop_req,
  input  logic [PC_W-1:0]  pc_next,
  input  logic             instr_valid,
  input  logic             halt,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             bp_we,
  input  logic [BI_W-1:0]  bp_idx,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       stat,
  output logic             core_en,
  output logic [1:0]       run_state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_STOP = 2'd3
  } state_t;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [3:0]        r_stat;
  logic              r_bp_hit;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_instr_cnt;
  logic [PC_W-1:0]   r_bp_addr [NUM_BP];
  logic [NUM_BP-1:0] r_bp_valid;

  logic              w_exc;
  logic [3:0]        w_exc_stat;
  logic              w_bp_match;

  always_comb begin
    w_exc      = 1'b1;
    w_exc_stat = STAT_AOK;
    if (!instr_valid)                   w_exc_stat = STAT_INS;
    else if (halt)                      w_exc_stat = STAT_HLT;
    else if (imem_error || dmem_error)  w_exc_stat = STAT_ADR;
    else                                w_exc      = 1'b0;
  end

  // Compare against the table as it stood before any write in this same cycle.
  always_comb begin
    w_bp_match = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (r_bp_valid[i] && (r_bp_addr[i] == pc_next)) w_bp_match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (run_req)       w_state_nxt = S_RUN;
        else if (step_req) w_state_nxt = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (w_exc)                             w_state_nxt = S_STOP;
        else if (w_bp_match)                   w_state_nxt = S_IDLE;
        else if (r_state == S_RUN && stop_req) w_state_nxt = S_IDLE;
        else if (r_state == S_STEP)            w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_STOP;
    endcase
  end

  always_comb begin
    core_en   = (r_state == S_RUN) || (r_state == S_STEP);
    run_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_stat      <= STAT_AOK;
      r_bp_hit    <= 1'b0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_bp_hit <= 1'b0;
      if (core_en) begin
        if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        if (w_exc) begin
          r_stat <= w_exc_stat;
        end else begin
          r_pc     <= pc_next;
          r_bp_hit <= w_bp_match;
          if (r_instr_cnt != '1) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bp_valid <= '0;
      for (int unsigned i = 0; i < NUM_BP; i++) r_bp_addr[i] <= '0;
    end else if (bp_we && (int'(bp_idx) < NUM_BP)) begin
      r_bp_valid[bp_idx] <= bp_valid;
      r_bp_addr[bp_idx]  <= bp_addr;
    end
  end

  assign pc        = r_pc;
  assign stat      = r_stat;
  assign bp_hit    = r_bp_hit;
  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: a behavioural model tracks the expected outputs every cycle,
// and literal expectations at key points pin the model.
module tb_proc_run_ctrl;

  localparam int PC_W   = 64;
  localparam int NUM_BP = 3;
  localparam int BI_W   = 2;
  localparam int CNT_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam logic [63:0] RPC = 64'd421;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run_req = 0, step_req = 0, stop_req = 0;
  logic [PC_W-1:0]  pc_next = '0;
  logic             instr_valid = 1, halt = 0, imem_error = 0, dmem_error = 0;
  logic             bp_we = 0;
  logic [BI_W-1:0]  bp_idx = '0;
  logic [PC_W-1:0]  bp_addr = '0;
  logic             bp_valid = 0;
  logic [PC_W-1:0]  pc;
  logic [3:0]       stat;
  logic             core_en;
  logic [1:0]       run_state;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  proc_run_ctrl #(.PC_W(PC_W), .RESET_PC(RPC), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .pc_next(pc_next), .instr_valid(instr_valid), .halt(halt), .imem_error(imem_error),
    .dmem_error(dmem_error), .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr),
    .bp_valid(bp_valid), .pc(pc), .stat(stat), .core_en(core_en), .run_state(run_state),
    .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode names rather than encodings, plain integer counters.
  typedef enum {M_IDLE, M_RUN, M_STEP, M_STOP} mode_t;
  mode_t       m_mode;
  logic [63:0] m_pc;
  logic [3:0]  m_stat;
  int          m_cyc, m_ins;
  bit          m_hit, m_valid = 0;
  logic [63:0] m_bpa [NUM_BP];
  bit          m_bpv [NUM_BP];

  function automatic int mode_code(input mode_t m);
    case (m)
      M_IDLE: return 0;
      M_RUN:  return 1;
      M_STEP: return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    bit hit;
    hit = 0;
    if (reset) begin
      m_mode = M_IDLE; m_pc = RPC; m_stat = 4'b1000; m_cyc = 0; m_ins = 0; m_hit = 0;
      for (int i = 0; i < NUM_BP; i++) begin m_bpa[i] = 0; m_bpv[i] = 0; end
      m_valid = 1;
    end else begin
      if (m_mode == M_IDLE) begin
        if (run_req) m_mode = M_RUN;
        else if (step_req) m_mode = M_STEP;
      end else if (m_mode != M_STOP) begin
        if (m_cyc < CMAX) m_cyc++;
        if (!instr_valid) begin m_stat = 4'b0001; m_mode = M_STOP; end
        else if (halt) begin m_stat = 4'b0100; m_mode = M_STOP; end
        else if (imem_error || dmem_error) begin m_stat = 4'b0010; m_mode = M_STOP; end
        else begin
          m_pc = pc_next;
          if (m_ins < CMAX) m_ins++;
          for (int i = 0; i < NUM_BP; i++) if (m_bpv[i] && m_bpa[i] == pc_next) hit = 1;
          if (hit) m_mode = M_IDLE;
          else if (m_mode == M_RUN && stop_req) m_mode = M_IDLE;
          else if (m_mode == M_STEP) m_mode = M_IDLE;
        end
      end
      m_hit = hit;
      if (bp_we && int'(bp_idx) < NUM_BP) begin
        m_bpa[bp_idx] = bp_addr;
        m_bpv[bp_idx] = bp_valid;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("stat", 64'(stat), 64'(m_stat));
      chk("run_state", 64'(run_state), 64'(mode_code(m_mode)));
      chk("core_en", 64'(core_en), 64'((m_mode == M_RUN) || (m_mode == M_STEP)));
      chk("bp_hit", 64'(bp_hit), 64'(m_hit));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
      chk("instr_cnt", 64'(instr_cnt), 64'(m_ins));
    end
  end

  bit auto_pc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_pc) pc_next = m_pc + 64'd10;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic bp_write(input int idx, input logic [63:0] a, input bit v);
    bp_we = 1; bp_idx = BI_W'(idx); bp_addr = a; bp_valid = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick(); reset = 0;
    chk("lit_rst_pc", pc, 64'd421);
    chk("lit_rst_stat", 64'(stat), 64'd8);
    chk("lit_rst_state", 64'(run_state), 64'd0);
    chk("lit_rst_en", 64'(core_en), 64'd0);
    chk("lit_rst_cnt", 64'({cycle_cnt, instr_cnt}), 64'd0);

    // Single step; stop_req in IDLE is ignored
    stop_req = 1; tick(); stop_req = 0;
    pc_next = 64'd431; step_req = 1; tick(); step_req = 0;
    chk("lit_step_en", 64'(core_en), 64'd1);
    tick();
    chk("lit_step_pc", pc, 64'd431);
    chk("lit_step_ins", 64'(instr_cnt), 64'd1);
    chk("lit_step_cyc", 64'(cycle_cnt), 64'd1);
    chk("lit_step_state", 64'(run_state), 64'd0);
    pc_next = 64'd500; step_req = 1; tick(); step_req = 0; tick();
    chk("lit_step2_pc", pc, 64'd500);
    tick();

    // Breakpoint stop on first commit
    do_reset(); auto_pc = 1; pc_next = m_pc + 64'd10;
    bp_write(2, 64'd431, 1); tick(); bp_we = 0;
    run_req = 1; tick(); run_req = 0;
    tick();
    chk("lit_bp_pc", pc, 64'd431);
    chk("lit_bp_state", 64'(run_state), 64'd0);
    chk("lit_bp_hit", 64'(bp_hit), 64'd1);
    chk("lit_bp_ins", 64'(instr_cnt), 64'd1);
    tick();
    chk("lit_bp_hit_off", 64'(bp_hit), 64'd0);
    // Same-cycle write uses pre-write table; out-of-range index ignored
    run_req = 1; tick(); run_req = 0;
    bp_write(2, 64'd441, 1); tick(); bp_we = 0;
    chk("lit_prewrite_state", 64'(run_state), 64'd1);
    bp_write(3, 64'd461, 1); tick(); bp_we = 0;
    tick();
    chk("lit_idx3_state", 64'(run_state), 64'd1);
    chk("lit_idx3_pc", pc, 64'd461);
    stop_req = 1; tick(); stop_req = 0;
    chk("lit_stop_state", 64'(run_state), 64'd0);
    tick();

    // Halt with dmem_error on third commit
    do_reset(); pc_next = m_pc + 64'd10;
    run_req = 1; tick(); run_req = 0;
    tick(); tick();
    halt = 1; dmem_error = 1; tick(); halt = 0; dmem_error = 0;
    chk("lit_halt_stat", 64'(stat), 64'd4);
    chk("lit_halt_pc", pc, 64'd441);
    chk("lit_halt_state", 64'(run_state), 64'd3);
    chk("lit_halt_ins", 64'(instr_cnt), 64'd2);
    chk("lit_halt_cyc", 64'(cycle_cnt), 64'd3);
    run_req = 1; step_req = 1; tick(); tick(); run_req = 0; step_req = 0;
    chk("lit_stop_sticky", 64'(run_state), 64'd3);

    // Invalid instruction + imem error + breakpoint in one cycle
    do_reset(); pc_next = m_pc + 64'd10;
    bp_write(0, 64'd431, 1); tick(); bp_we = 0;
    run_req = 1; tick(); run_req = 0;
    instr_valid = 0; imem_error = 1; tick(); instr_valid = 1; imem_error = 0;
    chk("lit_ins_stat", 64'(stat), 64'd1);
    chk("lit_ins_state", 64'(run_state), 64'd3);
    tick();
    chk("lit_ins_hit", 64'(bp_hit), 64'd0);

    // Saturation, run beats step, reset mid-run
    do_reset(); pc_next = m_pc + 64'd10;
    run_req = 1; step_req = 1; tick(); run_req = 0; step_req = 0;
    repeat (10) tick();
    chk("lit_sat_ins", 64'(instr_cnt), 64'd7);
    chk("lit_sat_cyc", 64'(cycle_cnt), 64'd7);
    chk("lit_sat_state", 64'(run_state), 64'd1);
    reset = 1; tick(); reset = 0;
    chk("lit_mid_pc", pc, 64'd421);
    chk("lit_mid_state", 64'(run_state), 64'd0);
    chk("lit_mid_cnt", 64'({cycle_cnt, instr_cnt}), 64'd0);
    tick(); tick();

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
